pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_pkg.sv | 15 +
 rtl/pc_target_mux.sv | 38 +++
 rtl/pc_gen.sv | 126 ++++++++++++
 tb/tb_pc_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared sel encodings and FSM state type for pc_gen
package pc_gen_pkg;

  // Execute-stage target select encodings; 2'b11 behaves like SEL_SEQ
  localparam logic [1:0] SEL_SEQ  = 2'b00;
  localparam logic [1:0] SEL_JAL  = 2'b01;
  localparam logic [1:0] SEL_JALR = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HOLD = 2'b01,
    ST_HALT = 2'b10
  } pc_state_t;

endpackage

// File: rtl/pc_target_mux.sv
// rtl/pc_target_mux.sv - redirect request, target select and misalignment trap
import pc_gen_pkg::*;

module pc_target_mux #(
  parameter int              XLEN    = 32,
  parameter logic [XLEN-1:0] TRAP_PC = XLEN'('h100)
) (
  input  logic            ex_valid,
  input  logic [1:0]      sel,
  input  logic            cond_branch,
  input  logic [XLEN-1:0] pc_imm,
  input  logic [XLEN-1:0] rs1_imm,
  output logic            req,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  logic [XLEN-1:0] raw_target;

  // Pick the redirect candidate, then divert word-misaligned targets to the trap vector
  always_comb begin
    req        = 1'b0;
    raw_target = pc_imm;
    if (ex_valid) begin
      case (sel)
        SEL_JAL:  req = 1'b1;
        SEL_JALR: begin
          req        = 1'b1;
          raw_target = {rs1_imm[XLEN-1:1], 1'b0};
        end
        default:  req = cond_branch;
      endcase
    end
    misaligned = req & raw_target[1];
    target     = misaligned ? TRAP_PC : raw_target;
  end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC generator with stall hold, pending redirect and halt; PC_GEN_PERF_CNT_EN adds counters
import pc_gen_pkg::*;

module pc_gen #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'('h0),
  parameter logic [XLEN-1:0] HALT_PC  = XLEN'('h6c),
  parameter logic [XLEN-1:0] TRAP_PC  = XLEN'('h100)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic [1:0]      sel,
  input  logic            cond_branch,
  input  logic [XLEN-1:0] pc_imm,
  input  logic [XLEN-1:0] rs1_imm,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] next_pc,
  output logic            redirect,
  output logic            halted,
`ifdef PC_GEN_PERF_CNT_EN
  output logic [31:0]     redirect_cnt,
  output logic [31:0]     stall_cnt,
`endif
  output logic            misalign_err
);

  pc_state_t       state, state_next;
  logic [XLEN-1:0] pend_target;
  logic            pend_mis;
  logic            pend_load;
  logic            req;
  logic [XLEN-1:0] target;
  logic            misaligned;

  pc_target_mux #(.XLEN(XLEN), .TRAP_PC(TRAP_PC)) u_mux (
    .ex_valid    (ex_valid),
    .sel         (sel),
    .cond_branch (cond_branch),
    .pc_imm      (pc_imm),
    .rs1_imm     (rs1_imm),
    .req         (req),
    .target      (target),
    .misaligned  (misaligned)
  );

  // Next-state and next-PC decode; the oldest captured redirect always wins over new ones
  always_comb begin
    state_next   = state;
    next_pc      = pc;
    redirect     = 1'b0;
    misalign_err = 1'b0;
    pend_load    = 1'b0;
    case (state)
      ST_RUN: begin
        if (!stall) begin
          if (req) begin
            next_pc      = target;
            redirect     = 1'b1;
            misalign_err = misaligned;
          end else if (pc == HALT_PC) begin
            next_pc    = HALT_PC;
            state_next = ST_HALT;
          end else begin
            next_pc = pc + XLEN'(4);
          end
        end else if (req) begin
          pend_load  = 1'b1;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          next_pc      = pend_target;
          redirect     = 1'b1;
          misalign_err = pend_mis;
          state_next   = ST_RUN;
        end
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_RUN;
    endcase
    halted = (state == ST_HALT);
    if (!rst_n) begin
      next_pc      = RESET_PC;
      redirect     = 1'b0;
      misalign_err = 1'b0;
      halted       = 1'b0;
    end
  end

  // PC, FSM state and one-deep pending redirect registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      pend_target <= '0;
      pend_mis    <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= next_pc;
      if (pend_load) begin
        pend_target <= target;
        pend_mis    <= misaligned;
      end else if (state == ST_HOLD && !stall) begin
        pend_target <= '0;
        pend_mis    <= 1'b0;
      end
    end
  end

`ifdef PC_GEN_PERF_CNT_EN
  // Free-running wrap-around counters of redirect cycles and non-halted stall cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      redirect_cnt <= redirect_cnt + {31'd0, redirect};
      stall_cnt    <= stall_cnt + {31'd0, (stall && state != ST_HALT)};
    end
  end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen; honours PC_GEN_PERF_CNT_EN
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        ex_valid = 1'b0;
  logic [1:0]  sel = 2'b00;
  logic        cond_branch = 1'b0;
  logic [31:0] pc_imm = '0;
  logic [31:0] rs1_imm = '0;
  logic [31:0] pc, next_pc;
  logic        redirect, halted, misalign_err;
`ifdef PC_GEN_PERF_CNT_EN
  logic [31:0] redirect_cnt, stall_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .ex_valid     (ex_valid),
    .sel          (sel),
    .cond_branch  (cond_branch),
    .pc_imm       (pc_imm),
    .rs1_imm      (rs1_imm),
    .pc           (pc),
    .next_pc      (next_pc),
    .redirect     (redirect),
    .halted       (halted),
`ifdef PC_GEN_PERF_CNT_EN
    .redirect_cnt (redirect_cnt),
    .stall_cnt    (stall_cnt),
`endif
    .misalign_err (misalign_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 1'b0; ex_valid = 1'b0; sel = 2'b00; cond_branch = 1'b0;
    pc_imm = '0; rs1_imm = '0;
  endtask

  task automatic jal(input logic [31:0] t);
    idle();
    ex_valid = 1'b1; sel = 2'b01; pc_imm = t;
    #1;
    chk("jal_redirect", 32'(redirect), 32'd1);
    step();
    chk("jal_pc", pc, t);
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_halted", 32'(halted), 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_release_pc", pc, 32'h0);
  endtask

  initial begin
    // Reset state with a request present: outputs must stay quiet
    ex_valid = 1'b1; sel = 2'b01; pc_imm = 32'h44;
    #2;
    chk("in_rst_pc", pc, 32'h0);
    chk("in_rst_redirect", 32'(redirect), 32'd0);
    chk("in_rst_next_pc", next_pc, 32'h0);
    chk("in_rst_halted", 32'(halted), 32'd0);
    do_reset();

    // Sequential fetch after reset
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("seq_pc", pc, 32'(4 * i));
    end
    chk("seq_redirect", 32'(redirect), 32'd0);

    // jalr: low bit cleared, then misaligned target traps
    jal(32'h10);
    ex_valid = 1'b1; sel = 2'b10; rs1_imm = 32'h41;
    #1;
    chk("jalr_next_pc", next_pc, 32'h40);
    chk("jalr_redirect", 32'(redirect), 32'd1);
    chk("jalr_mis", 32'(misalign_err), 32'd0);
    step();
    chk("jalr_pc", pc, 32'h40);
    rs1_imm = 32'h42;
    #1;
    chk("trap_next_pc", next_pc, 32'h100);
    chk("trap_mis", 32'(misalign_err), 32'd1);
    step();
    chk("trap_pc", pc, 32'h100);
    idle();
    #1;
    chk("trap_mis_clear", 32'(misalign_err), 32'd0);
    chk("trap_seq", next_pc, 32'h104);

    // sel=11 behaves as sequential/branch
    ex_valid = 1'b1; sel = 2'b11; pc_imm = 32'h20;
    #1;
    chk("sel11_nobr", next_pc, 32'h104);
    chk("sel11_nobr_redir", 32'(redirect), 32'd0);
    cond_branch = 1'b1;
    #1;
    chk("sel11_br", next_pc, 32'h20);
    step();
    chk("sel11_br_pc", pc, 32'h20);

    // Stalled branch is held pending; later jal during HOLD dropped
    stall = 1'b1; ex_valid = 1'b1; sel = 2'b00; cond_branch = 1'b1; pc_imm = 32'h80;
    #1;
    chk("hold1_redirect", 32'(redirect), 32'd0);
    step();
    chk("hold1_pc", pc, 32'h20);
    cond_branch = 1'b0; sel = 2'b01; pc_imm = 32'h90;
    #1;
    chk("hold2_next_pc", next_pc, 32'h20);
    step();
    chk("hold2_pc", pc, 32'h20);
    stall = 1'b0;
    #1;
    chk("hold_rel_redirect", 32'(redirect), 32'd1);
    chk("hold_rel_next_pc", next_pc, 32'h80);
    step();
    chk("hold_rel_pc", pc, 32'h80);
    idle();
    #1;
    chk("hold_after_redirect", 32'(redirect), 32'd0);
    chk("hold_after_next_pc", next_pc, 32'h84);

    // Stall without request just holds
    stall = 1'b1;
    #1;
    chk("stall_next_pc", next_pc, 32'h80);
    step();
    chk("stall_pc", pc, 32'h80);

    // Misaligned target captured during stall
    ex_valid = 1'b1; sel = 2'b01; pc_imm = 32'h82;
    step();
    idle();
    #1;
    chk("pend_mis_next_pc", next_pc, 32'h100);
    chk("pend_mis_err", 32'(misalign_err), 32'd1);
    step();
    chk("pend_mis_pc", pc, 32'h100);

    // Reset mid-HOLD discards the pending target
    stall = 1'b1; ex_valid = 1'b1; sel = 2'b01; pc_imm = 32'h50;
    step();
    rst_n = 1'b0;
    #1;
    chk("hold_rst_pc", pc, 32'h0);
    step();
    idle();
    rst_n = 1'b1;
    #1;
    chk("hold_rst_redirect", 32'(redirect), 32'd0);
    chk("hold_rst_next_pc", next_pc, 32'h4);
    step();
    chk("hold_rst_fetch", pc, 32'h4);

    // Halt: request at HALT_PC wins, then idle cycle halts
    jal(32'h60);
    for (int i = 0; i < 3; i++) step();
    chk("pre_halt_pc", pc, 32'h6c);
    jal(32'h6c);
    chk("halt_prio_halted", 32'(halted), 32'd0);
    #1;
    chk("halt_entry_next_pc", next_pc, 32'h6c);
    step();
    chk("halted", 32'(halted), 32'd1);
    ex_valid = 1'b1; sel = 2'b01; pc_imm = 32'h200;
    for (int i = 0; i < 10; i++) begin
      stall = i[0];
      #1;
      chk("halt_redirect", 32'(redirect), 32'd0);
      chk("halt_next_pc", next_pc, 32'h6c);
      step();
      chk("halt_pc", pc, 32'h6c);
    end
    rst_n = 1'b0;
    #1;
    chk("halt_rst_pc", pc, 32'h0);
    chk("halt_rst_halted", 32'(halted), 32'd0);
    step();
    idle();
    rst_n = 1'b1;
    step();
    chk("halt_rst_fetch", pc, 32'h4);

    // PC wraps from all-ones-minus-3
    jal(32'hFFFF_FFFC);
    #1;
    chk("wrap_next_pc", next_pc, 32'h0);
    step();
    chk("wrap_pc", pc, 32'h0);

`ifdef PC_GEN_PERF_CNT_EN
    do_reset();
    chk("cnt_rst_redirect", redirect_cnt, 32'd0);
    chk("cnt_rst_stall", stall_cnt, 32'd0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) step();
    jal(32'h100);
    jal(32'h200);
    chk("stall_cnt", stall_cnt, 32'd3);
    chk("redirect_cnt", redirect_cnt, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
